// File: rtl/aux_layer_ctrl.sv
// Auxiliary layer controller: sequences upsample (one pass) and route (up to two passes)
// layers, computing each pass's row stride with a serial shift-add multiplier.
module aux_layer_ctrl #(
    parameter int unsigned W_SIZE    = 10,
    parameter int unsigned W_CHANNEL = 11,
    parameter int unsigned IFM_AW    = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          i_start,
    input  logic                          i_mode,
    input  logic [W_SIZE-1:0]             i_width,
    input  logic [W_SIZE-1:0]             i_height,
    input  logic [W_CHANNEL-1:0]          i_chn_a,
    input  logic [W_CHANNEL-1:0]          i_chn_b,
    input  logic [IFM_AW-1:0]             i_base_a,
    input  logic [IFM_AW-1:0]             i_base_b,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_err,
    output logic                          o_pass,
    output logic [W_SIZE-1:0]             o_q_width,
    output logic [W_SIZE-1:0]             o_q_height,
    output logic [W_CHANNEL-1:0]          o_q_channel,
    output logic [W_CHANNEL-1:0]          o_q_channel_out,
    output logic [W_CHANNEL-1:0]          o_q_route_chn_offset,
    output logic [W_SIZE+W_CHANNEL-1:0]   o_q_row_stride,
    output logic [IFM_AW-1:0]             o_q_route_offset,
    output logic                          o_q_as_mode,
    output logic                          o_q_as_start,
    input  logic                          i_as_done
);

    localparam int unsigned W_STRIDE = W_SIZE + W_CHANNEL;
    localparam int unsigned W_CNT    = $clog2(W_CHANNEL + 1);
    localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(W_CHANNEL - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_CALC, S_ISSUE, S_WAIT, S_NEXT, S_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic                   mode_q, mode_d;
    logic [W_SIZE-1:0]      width_q, width_d, height_q, height_d;
    logic [W_CHANNEL-1:0]   chn_a_q, chn_a_d, chn_b_q, chn_b_d;
    logic [IFM_AW-1:0]      base_a_q, base_a_d, base_b_q, base_b_d;
    logic                   pass_q, pass_d;
    logic [W_STRIDE-1:0]    acc_q, acc_d, mcand_q, mcand_d;
    logic [W_CHANNEL-1:0]   mplier_q, mplier_d;
    logic [W_CNT-1:0]       cnt_q, cnt_d;
    logic                   busy_q, busy_d, done_q, done_d, err_q, err_d, start_q, start_d;
    logic [W_CHANNEL-1:0]   channel_q, channel_d, chn_out_q, chn_out_d, chn_off_q, chn_off_d;
    logic [W_STRIDE-1:0]    stride_q, stride_d;
    logic [IFM_AW-1:0]      offset_q, offset_d;

    logic [W_CHANNEL:0]     chn_sum;
    logic                   cfg_bad;
    logic [W_STRIDE-1:0]    acc_add;

    // Channel sum carries one extra bit so route overflow is visible
    assign chn_sum = {1'b0, chn_a_q} + {1'b0, chn_b_q};
    assign cfg_bad = (width_q == '0) || (height_q == '0) || (chn_a_q == '0)
                   || (mode_q && chn_sum[W_CHANNEL]);
    assign acc_add = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        width_d   = width_q;
        height_d  = height_q;
        chn_a_d   = chn_a_q;
        chn_b_d   = chn_b_q;
        base_a_d  = base_a_q;
        base_b_d  = base_b_q;
        pass_d    = pass_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        start_d   = 1'b0;
        channel_d = channel_q;
        chn_out_d = chn_out_q;
        chn_off_d = chn_off_q;
        stride_d  = stride_q;
        offset_d  = offset_q;

        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    mode_d   = i_mode;
                    width_d  = i_width;
                    height_d = i_height;
                    chn_a_d  = i_chn_a;
                    chn_b_d  = i_chn_b;
                    base_a_d = i_base_a;
                    base_b_d = i_base_b;
                    pass_d   = 1'b0;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                if (cfg_bad) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    channel_d = chn_a_q;
                    chn_out_d = mode_q ? chn_sum[W_CHANNEL-1:0] : chn_a_q;
                    chn_off_d = '0;
                    offset_d  = mode_q ? base_a_q : '0;
                    mcand_d   = W_STRIDE'(width_q);
                    mplier_d  = chn_a_q;
                    acc_d     = '0;
                    cnt_d     = '0;
                    state_d   = S_CALC;
                end
            end
            S_CALC: begin
                // One multiplier bit per cycle, LSB first
                acc_d    = acc_add;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + W_CNT'(1);
                if (cnt_q == CNT_LAST) begin
                    stride_d = acc_add;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                start_d = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (i_as_done) begin
                    if (mode_q && (chn_b_q != '0) && !pass_q) begin
                        pass_d  = 1'b1;
                        state_d = S_NEXT;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_NEXT: begin
                channel_d = chn_b_q;
                chn_off_d = chn_a_q;
                offset_d  = base_b_q;
                mcand_d   = W_STRIDE'(width_q);
                mplier_d  = chn_b_q;
                acc_d     = '0;
                cnt_d     = '0;
                state_d   = S_CALC;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            mode_q    <= 1'b0;
            width_q   <= '0;
            height_q  <= '0;
            chn_a_q   <= '0;
            chn_b_q   <= '0;
            base_a_q  <= '0;
            base_b_q  <= '0;
            pass_q    <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            start_q   <= 1'b0;
            channel_q <= '0;
            chn_out_q <= '0;
            chn_off_q <= '0;
            stride_q  <= '0;
            offset_q  <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            width_q   <= width_d;
            height_q  <= height_d;
            chn_a_q   <= chn_a_d;
            chn_b_q   <= chn_b_d;
            base_a_q  <= base_a_d;
            base_b_q  <= base_b_d;
            pass_q    <= pass_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            start_q   <= start_d;
            channel_q <= channel_d;
            chn_out_q <= chn_out_d;
            chn_off_q <= chn_off_d;
            stride_q  <= stride_d;
            offset_q  <= offset_d;
        end
    end

    assign o_busy               = busy_q;
    assign o_done               = done_q;
    assign o_err                = err_q;
    assign o_pass               = pass_q;
    assign o_q_width            = width_q;
    assign o_q_height           = height_q;
    assign o_q_as_mode          = mode_q;
    assign o_q_channel          = channel_q;
    assign o_q_channel_out      = chn_out_q;
    assign o_q_route_chn_offset = chn_off_q;
    assign o_q_row_stride       = stride_q;
    assign o_q_route_offset     = offset_q;
    assign o_q_as_start         = start_q;

endmodule

// File: doc/aux_layer_ctrl.md
AUX_LAYER_CTRL -- requirements
Module: aux_layer_ctrl

Interface
REQ-001 SHALL have parameter W_SIZE, default 10, width/height field width.
REQ-002 SHALL have parameter W_CHANNEL, default 11, channel field width.
REQ-003 SHALL have parameter IFM_AW, default 16, feature-map buffer address width.
REQ-004 clk  in  1  single clock; all flops rising-edge.
REQ-005 rstn  in  1  asynchronous active-low reset.
REQ-006 i_start  in  1  layer start pulse; i_mode  in  1  0=upsample, 1=route.
REQ-007 i_width, i_height  in  W_SIZE each  input FM dimensions.
REQ-008 i_chn_a, i_chn_b  in  W_CHANNEL each  source channels; i_chn_b=0 means single source.
REQ-009 i_base_a, i_base_b  in  IFM_AW each  source base addresses (route).
REQ-010 o_busy  out  1; o_done  out  1  pulse; o_err  out  1  pulse; o_pass  out  1  current pass (0=A, 1=B).
REQ-011 Sequencer side, all registered outputs: o_q_width, o_q_height (W_SIZE); o_q_channel, o_q_channel_out, o_q_route_chn_offset (W_CHANNEL); o_q_row_stride (W_SIZE+W_CHANNEL); o_q_route_offset (IFM_AW); o_q_as_mode (1); o_q_as_start (1 pulse).
REQ-012 i_as_done  in  1  sequencer completion pulse.

Function
REQ-013 FSM states SHALL be IDLE, CHECK, CALC, ISSUE, WAIT, NEXT, DONE.
REQ-014 IDLE: on i_start=1, latch all i_* config and go to CHECK; i_start in any other state SHALL be ignored.
REQ-015 CHECK (1 cycle): error if width=0, height=0, chn_a=0, or (route and chn_a+chn_b, computed in W_CHANNEL+1 bits, > 2^W_CHANNEL-1); on error pulse o_err and o_done together for one cycle, return to IDLE, no o_q_as_start.
REQ-016 Upsample: chn_b and bases ignored; exactly one pass.
REQ-017 CALC: o_q_row_stride = width*channel_of_current_pass via shift-add multiplier, exactly W_CHANNEL cycles, result exact (no truncation).
REQ-018 Pass A drive: o_q_channel=chn_a, o_q_route_offset=base_a, o_q_route_chn_offset=0.
REQ-019 Pass B drive: o_q_channel=chn_b, o_q_route_offset=base_b, o_q_route_chn_offset=chn_a.
REQ-020 o_q_channel_out SHALL be chn_a (upsample) or chn_a+chn_b (route), both passes.
REQ-021 o_q_width, o_q_height, o_q_as_mode SHALL equal latched values; all o_q_* stable from ISSUE through WAIT.
REQ-022 ISSUE: o_q_as_start=1 for exactly one cycle, then WAIT.
REQ-023 WAIT: hold until i_as_done=1; i_as_done in any other state SHALL be ignored.
REQ-024 On done in WAIT: route with chn_b!=0 and o_pass=0 -> NEXT (set o_pass=1, 1 cycle) -> CALC; otherwise DONE.
REQ-025 DONE: o_done=1 for one cycle, then IDLE.
REQ-026 o_busy=1 in every state except IDLE.
REQ-027 Latency start-to-first o_q_as_start: 1 (latch) + 1 (CHECK) + W_CHANNEL (CALC) + 1 cycles = W_CHANNEL+3.
REQ-028 Latency i_as_done(last pass)-to-o_done: 1 cycle.

Reset
REQ-029 On rstn=0 state SHALL go to IDLE immediately; all outputs and latched config SHALL be 0.
REQ-030 Reset mid-operation SHALL abort without issuing further o_q_as_start or o_done.

Verification
REQ-031 Upsample w=13,h=13,chn_a=256 -> one o_q_as_start at cycle 14, row_stride=3328, channel_out=256, chn_offset=0; i_as_done -> o_done next cycle.
REQ-032 Route chn_a=128,chn_b=256,base_a=0x0100,base_b=0x2000 -> pass A (chn 128, offset 0x0100, chn_offset 0, channel_out 384), pass B (chn 256, offset 0x2000, chn_offset 128); two starts, one o_done.
REQ-033 Route chn_b=0 -> single pass, o_pass stays 0.
REQ-034 Width=0, or route chn_a=2000,chn_b=100 -> o_err and o_done same cycle, no start, o_busy low after.
REQ-035 i_start during WAIT and i_as_done during CALC -> both ignored, config and sequence unchanged.
REQ-036 rstn low during WAIT pass A -> all outputs 0, no pass B start; new i_start after release runs normally.
